// File: rtl/global_sram_bcast.sv
// global_sram_bcast
//   Snoops the read requests a read controller issues to the global SRAM,
//   captures the returning read data one cycle later, and broadcasts each word
//   to the cores through a small FIFO with a valid/ready output. A pass is
//   started by `start` and ends once `num_words` beats have been delivered.
//
// Optional feature:
//   GBCAST_ADDR_TAG_EN  when defined, each FIFO entry also stores the 5-bit
//                       SRAM address and bcast_addr carries it; otherwise the
//                       FIFO holds data only and bcast_addr is tied to 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, num_words     pass start pulse and beat count (sampled on start)
//   global_sram_ren      SRAM read enable issued by the read controller
//   global_sram_raddr    SRAM read address issued with global_sram_ren
//   global_sram_rdata    SRAM read data, valid one cycle after ren
//   bcast_vld/rdy        broadcast handshake (see below)
//   bcast_data/addr      head-of-FIFO payload and its SRAM address tag
//   almost_full          FIFO holds FIFO_DEPTH-1 or more entries
//   overflow             sticky: a word was dropped because the FIFO was full
//   done                 one-cycle pulse at the end of a pass
//   state_dbg            current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a beat transfers in any cycle where bcast_vld and bcast_rdy are
// both 1. bcast_vld never depends on bcast_rdy, and bcast_data/bcast_addr
// hold steady while bcast_vld=1 and bcast_rdy=0.
module global_sram_bcast #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        num_words,
  input  logic              global_sram_ren,
  input  logic [4:0]        global_sram_raddr,
  input  logic [DATA_W-1:0] global_sram_rdata,
  output logic              bcast_vld,
  output logic [DATA_W-1:0] bcast_data,
  output logic [4:0]        bcast_addr,
  input  logic              bcast_rdy,
  output logic              almost_full,
  output logic              overflow,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef GBCAST_ADDR_TAG_EN
  localparam int ENT_W = DATA_W + 5;
`else
  localparam int ENT_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [5:0]        nw_q;
  logic [5:0]        delivered;
  logic              ren_d1;
  logic [4:0]        raddr_d1;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [ENT_W-1:0]  entry;
  logic              accept_start;
  logic              push_req, push_ok, pop, full;

  assign accept_start = (state == IDLE) && start;
  // Read data returned outside RUN is simply discarded.
  assign push_req     = ren_d1 && (state == RUN);
  assign pop          = bcast_vld && bcast_rdy;
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push_ok      = push_req && (!full || pop);

`ifdef GBCAST_ADDR_TAG_EN
  assign entry = {global_sram_rdata, raddr_d1};
`else
  assign entry = global_sram_rdata;
  logic unused_raddr;
  assign unused_raddr = ^raddr_d1;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; the exit from RUN uses the registered delivered count,
  // so DONE follows one cycle after the count reaches num_words.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (delivered == nw_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done      = (state == DONE);
  assign state_dbg = state;

  // Request pipeline aligning address with the returning read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_d1   <= 1'b0;
      raddr_d1 <= '0;
    end else begin
      ren_d1   <= global_sram_ren;
      raddr_d1 <= global_sram_raddr;
    end
  end

  // FIFO control, delivered counter and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      delivered <= '0;
      nw_q      <= '0;
      overflow  <= 1'b0;
    end else if (accept_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      delivered <= '0;
      nw_q      <= num_words;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        delivered <= delivered + 6'd1;
      end
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  assign head        = mem[rd_ptr];
  assign bcast_vld   = (count != '0);
  assign almost_full = (count >= CNT_W'(FIFO_DEPTH - 1));
  assign bcast_data  = bcast_vld ? head[ENT_W-1 -: DATA_W] : '0;
`ifdef GBCAST_ADDR_TAG_EN
  assign bcast_addr  = bcast_vld ? head[4:0] : 5'd0;
`else
  assign bcast_addr  = 5'd0;
`endif

endmodule
